cache_line: RTL and testbench

- One set of a way-partitioned, set-associative cache, in the DAWG style (Dynamically Allocated Way Guard).
- An OS-level request loads a way mask (the policy hitmap) that confines both lookups and replacement to the current protection domain.
- User requests look up a tag, report hit combinationally, and fill or update replacement state on the clock edge.
- Replacement metadata changes never cross the active partition, so two domains with disjoint masks cannot observe each other.

---
 rtl/cache_line.sv | 168 ++++++++++++++++
 tb/tb_cache_line.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_line.sv
// One set of a way-partitioned (DAWG-style) cache: tag lookup, fill and
// NRU / tree-PLRU replacement confined to the active way mask.
module cache_line #(
  parameter int NUM_WAYS   = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int POLICY     = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           os_req,
  input  logic [NUM_WAYS-1:0]            hitmap,
  input  logic                           user_req,
  input  logic [ADDR_WIDTH-1:0]          addr,
  output logic                           hit,
  output logic [NUM_WAYS-1:0]            metadata_o,
  output logic [ADDR_WIDTH*NUM_WAYS-1:0] all_tags_o,
  output logic [NUM_WAYS-1:0]            all_valid_o,
  output logic [NUM_WAYS-1:0]            policy_hitmap_o
);

  localparam int LW = $clog2(NUM_WAYS);

  logic [ADDR_WIDTH-1:0] tags [NUM_WAYS];
  logic [NUM_WAYS-1:0]   valid;
  logic [NUM_WAYS-1:0]   meta;
  logic [NUM_WAYS-1:0]   pmask;

  logic [NUM_WAYS-1:0] match;
  logic [NUM_WAYS-1:0] inval;
  logic [NUM_WAYS-1:0] cand;
  logic                any_hit;
  logic                any_inval;
  logic [LW-1:0]       hit_way;
  logic [LW-1:0]       inv_way;
  logic [LW-1:0]       nru_way;
  logic [LW-1:0]       plru_way;
  logic [LW-1:0]       victim;
  logic [LW-1:0]       touch_way;
  logic [NUM_WAYS-1:0] oh;
  logic [NUM_WAYS-1:0] meta_nru;
  logic [NUM_WAYS-1:0] meta_plru;
  logic [NUM_WAYS-1:0] meta_nxt;
  logic [LW:0]         nd;
  logic [NUM_WAYS-1:0] lm;
  logic [NUM_WAYS-1:0] rm;
  logic [LW:0]         leaf;
  logic [LW:0]         node;
  logic [NUM_WAYS-1:0] sm;

  function automatic logic [LW-1:0] first_one(
    input logic [NUM_WAYS-1:0] v
  );
    first_one = '0;
    for (int i = NUM_WAYS-1; i >= 0; i--)
      if (v[i]) first_one = LW'(i);
  endfunction

  // Ways under tree node `nd_i` sitting at depth `depth` (root = 1, depth 0)
  function automatic logic [NUM_WAYS-1:0] sub_ways(
    input int nd_i,
    input int depth
  );
    int cnt;
    int first;
    cnt = NUM_WAYS >> depth;
    first = nd_i * cnt - NUM_WAYS;
    sub_ways = '0;
    for (int i = 0; i < NUM_WAYS; i++)
      if (i >= first && i < first + cnt)
        sub_ways[i] = 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_WAYS; i++)
      match[i] = valid[i] & pmask[i] &
                 (tags[i] == addr);
  end

  assign inval     = ~valid & pmask;
  assign any_hit   = |match;
  assign any_inval = |inval;
  assign hit       = user_req & ~os_req & any_hit;
  assign hit_way   = first_one(match);
  assign inv_way   = first_one(inval);

  always_comb begin
    cand = pmask & ~meta;
    if (any_inval)
      nru_way = inv_way;
    else if (|cand)
      nru_way = first_one(cand);
    else
      nru_way = first_one(pmask);
  end

  // Tree walk steers around subtrees holding no ways of the partition
  always_comb begin
    nd = (LW+1)'(1);
    lm = '0;
    rm = '0;
    for (int d = 0; d < LW; d++) begin
      lm = sub_ways(int'({nd[LW-1:0], 1'b0}), d+1) & pmask;
      rm = sub_ways(int'({nd[LW-1:0], 1'b1}), d+1) & pmask;
      if (~|rm)
        nd = {nd[LW-1:0], 1'b0};
      else if (~|lm)
        nd = {nd[LW-1:0], 1'b1};
      else
        nd = {nd[LW-1:0], meta[nd[LW-1:0]]};
    end
    plru_way = any_inval ? inv_way : nd[LW-1:0];
  end

  assign victim    = (POLICY == 1) ? plru_way : nru_way;
  assign touch_way = any_hit ? hit_way : victim;

  always_comb begin
    oh = '0;
    oh[touch_way] = 1'b1;
    meta_nru = meta | oh;
    if ((meta_nru & pmask) == pmask)
      meta_nru = (meta & ~pmask) | oh;
  end

  // A node only moves when its whole subtree belongs to the partition
  always_comb begin
    meta_plru = meta;
    leaf = {1'b1, touch_way};
    node = '0;
    sm   = '0;
    for (int d = 0; d < LW; d++) begin
      node = leaf >> (LW - d);
      sm = sub_ways(int'(node), d);
      if ((sm & pmask) == sm)
        meta_plru[node[LW-1:0]] = ~leaf[LW-1-d];
    end
  end

  assign meta_nxt = (POLICY == 1) ? meta_plru : meta_nru;

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid <= '0;
      meta  <= '0;
      pmask <= '1;
      for (int i = 0; i < NUM_WAYS; i++)
        tags[i] <= '0;
    end else if (os_req) begin
      if (|hitmap)
        pmask <= hitmap;
    end else if (user_req) begin
      meta <= meta_nxt;
      if (!any_hit) begin
        tags[victim]  <= addr;
        valid[victim] <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_WAYS; g++) begin : g_tags
    assign all_tags_o[g*ADDR_WIDTH +: ADDR_WIDTH] = tags[g];
  end

  assign metadata_o      = meta;
  assign all_valid_o     = valid;
  assign policy_hitmap_o = pmask;

endmodule

// File: tb/tb_cache_line.sv
// Randomized scoreboard bench for cache_line: two NRU sets and one
// PLRU set driven together and compared against a way-level model.
module tb_cache_line;

  typedef struct packed {
    logic [63:0] tags;
    logic [7:0]  valid;
    logic [7:0]  meta;
    logic [7:0]  pol;
  } model_t;

  typedef struct packed {
    logic   ha;
    logic   hb;
    logic   hp;
    model_t sa;
    model_t sb;
    model_t sp;
  } item_t;

  logic       clk;
  logic       reset;
  logic       os_req;
  logic [7:0] hitmap;
  logic       user_req;
  logic [7:0] addr_a;
  logic [7:0] addr_b;

  logic        hit_a, hit_b, hit_p;
  logic [7:0]  meta_a, meta_b, meta_p;
  logic [63:0] tags_a, tags_b, tags_p;
  logic [7:0]  valid_a, valid_b, valid_p;
  logic [7:0]  pol_a, pol_b, pol_p;

  int checks = 0;
  int errors = 0;

  model_t ma, mb, mp;
  item_t  sbq [$];

  cache_line #(.NUM_WAYS(8), .ADDR_WIDTH(8), .POLICY(0)) u_a (
    .clk(clk), .reset(reset), .os_req(os_req), .hitmap(hitmap),
    .user_req(user_req), .addr(addr_a), .hit(hit_a),
    .metadata_o(meta_a), .all_tags_o(tags_a),
    .all_valid_o(valid_a), .policy_hitmap_o(pol_a)
  );

  cache_line #(.NUM_WAYS(8), .ADDR_WIDTH(8), .POLICY(0)) u_b (
    .clk(clk), .reset(reset), .os_req(os_req), .hitmap(hitmap),
    .user_req(user_req), .addr(addr_b), .hit(hit_b),
    .metadata_o(meta_b), .all_tags_o(tags_b),
    .all_valid_o(valid_b), .policy_hitmap_o(pol_b)
  );

  cache_line #(.NUM_WAYS(8), .ADDR_WIDTH(8), .POLICY(1)) u_p (
    .clk(clk), .reset(reset), .os_req(os_req), .hitmap(hitmap),
    .user_req(user_req), .addr(addr_a), .hit(hit_p),
    .metadata_o(meta_p), .all_tags_o(tags_p),
    .all_valid_o(valid_p), .policy_hitmap_o(pol_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic model_t rst_state();
    model_t m;
    m.tags  = '0;
    m.valid = '0;
    m.meta  = '0;
    m.pol   = 8'hFF;
    return m;
  endfunction

  function automatic int m_hitway(model_t m, logic [7:0] a);
    int r;
    r = -1;
    for (int i = 7; i >= 0; i--)
      if (m.valid[i] && m.pol[i] && m.tags[i*8 +: 8] == a)
        r = i;
    return r;
  endfunction

  function automatic bit any_in(model_t m, int lo, int hi);
    bit r;
    r = 0;
    for (int i = lo; i <= hi; i++)
      if (m.pol[i]) r = 1;
    return r;
  endfunction

  function automatic bit full_in(model_t m, int lo, int hi);
    bit r;
    r = 1;
    for (int i = lo; i <= hi; i++)
      if (!m.pol[i]) r = 0;
    return r;
  endfunction

  function automatic int first_inv(model_t m);
    int r;
    r = -1;
    for (int i = 7; i >= 0; i--)
      if (m.pol[i] && !m.valid[i]) r = i;
    return r;
  endfunction

  function automatic int nru_victim(model_t m);
    int r;
    r = -1;
    for (int i = 7; i >= 0; i--)
      if (m.pol[i] && !m.meta[i]) r = i;
    if (r < 0)
      for (int i = 7; i >= 0; i--)
        if (m.pol[i]) r = i;
    return r;
  endfunction

  function automatic int plru_victim(model_t m);
    int h, q, r, base;
    h = !any_in(m, 0, 3) ? 1 :
        !any_in(m, 4, 7) ? 0 : int'(m.meta[1]);
    base = 4 * h;
    q = !any_in(m, base, base+1) ? 1 :
        !any_in(m, base+2, base+3) ? 0 :
        int'(m.meta[2+h]);
    base = base + 2 * q;
    r = !m.pol[base]   ? 1 :
        !m.pol[base+1] ? 0 :
        int'(m.meta[4 + base/2]);
    return base + r;
  endfunction

  function automatic model_t m_step(model_t m, bit os,
                                    logic [7:0] hm, bit ur,
                                    logic [7:0] a, bit plru);
    int w, lo;
    if (os) begin
      if (hm != 0) m.pol = hm;
    end else if (ur) begin
      w = m_hitway(m, a);
      if (w < 0) begin
        w = first_inv(m);
        if (w < 0) w = plru ? plru_victim(m) : nru_victim(m);
        m.tags[w*8 +: 8] = a;
        m.valid[w] = 1'b1;
      end
      if (plru) begin
        if (full_in(m, 0, 7)) m.meta[1] = (w < 4);
        lo = (w / 4) * 4;
        if (full_in(m, lo, lo+3))
          m.meta[2 + w/4] = ((w / 2) % 2 == 0);
        lo = (w / 2) * 2;
        if (full_in(m, lo, lo+1))
          m.meta[4 + w/2] = (w % 2 == 0);
      end else begin
        m.meta[w] = 1'b1;
        if ((m.meta & m.pol) == m.pol)
          m.meta = (m.meta & ~m.pol) | (8'd1 << w);
      end
    end
    return m;
  endfunction

  // Drive one cycle; returns just after the following negedge
  task automatic step(input bit rn, input bit os,
                      input logic [7:0] hm, input bit ur,
                      input logic [7:0] aa, input logic [7:0] ab);
    item_t it;
    @(posedge clk);
    #2;
    reset = rn; os_req = os; hitmap = hm;
    user_req = ur; addr_a = aa; addr_b = ab;
    it.ha = ur && !os && (m_hitway(ma, aa) >= 0);
    it.hb = ur && !os && (m_hitway(mb, ab) >= 0);
    it.hp = ur && !os && (m_hitway(mp, aa) >= 0);
    it.sa = ma;
    it.sb = mb;
    it.sp = mp;
    sbq.push_back(it);
    if (!rn) begin
      ma = rst_state(); mb = rst_state(); mp = rst_state();
    end else begin
      ma = m_step(ma, os, hm, ur, aa, 1'b0);
      mb = m_step(mb, os, hm, ur, ab, 1'b0);
      mp = m_step(mp, os, hm, ur, aa, 1'b1);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic req(input logic [7:0] a);
    step(1'b1, 1'b0, 8'h00, 1'b1, a, a);
  endtask

  task automatic os(input logic [7:0] hm);
    step(1'b1, 1'b1, hm, 1'b0, 8'h00, 8'h00);
  endtask

  always @(negedge clk) begin
    item_t it;
    if (sbq.size() > 0) begin
      it = sbq.pop_front();
      chk("hit_a", hit_a, it.ha);
      chk("hit_b", hit_b, it.hb);
      chk("hit_p", hit_p, it.hp);
      chk("st_a", {tags_a, valid_a, meta_a, pol_a}, it.sa);
      chk("st_b", {tags_b, valid_b, meta_b, pol_b}, it.sb);
      chk("st_p", {tags_p, valid_p, meta_p, pol_p}, it.sp);
    end
  end

  initial begin
    logic [7:0] x, y, hm;
    logic [7:0] hms [6];
    bit eb;
    int r;
    hms = '{8'h00, 8'h0F, 8'hF0, 8'hFF, 8'h03, 8'hC3};
    reset = 1'b0; os_req = 1'b0; hitmap = '0;
    user_req = 1'b0; addr_a = '0; addr_b = '0;
    ma = rst_state(); mb = rst_state(); mp = rst_state();

    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
    chk("rst_pol", pol_a, 8'hFF);
    os(8'h0F);
    idle();
    chk("os_pol", pol_a, 8'h0F);
    chk("os_valid", valid_a, 8'h00);
    chk("os_meta", meta_a, 8'h00);

    req(8'h12);
    chk("miss_hit", hit_a, 1'b0);
    idle();
    chk("fill_tag0", tags_a[7:0], 8'h12);
    chk("fill_v0", valid_a[0], 1'b1);
    req(8'h12);
    chk("rehit", hit_a, 1'b1);
    idle();
    chk("rehit_tags", tags_a, 64'h12);

    req(8'h20); req(8'h21); req(8'h22); req(8'h23);
    idle();
    chk("evict_tag0", tags_a[7:0], 8'h23);
    chk("evict_v_hi", valid_a[7:4], 4'h0);
    chk("evict_m_hi", meta_a[7:4], 4'h0);
    chk("evict_meta", meta_a, 8'h09);

    step(1'b1, 1'b1, 8'hFF, 1'b1, 8'h20, 8'h20);
    chk("os_user_hit", hit_a, 1'b0);
    idle();
    chk("os_user_pol", pol_a, 8'hFF);
    chk("os_user_tags", tags_a, 64'h22212023);
    chk("os_user_meta", meta_a, 8'h09);
    os(8'h00);
    idle();
    chk("os_zero_pol", pol_a, 8'hFF);

    step(1'b0, 1'b0, 8'h00, 1'b1, 8'h20, 8'h20);
    idle();
    chk("midrst_valid", valid_a, 8'h00);
    os(8'hF0);
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 3);
      if (r == 0) os(8'hF0);
      else if (r == 1) os(8'h0F);
      else begin
        x = 8'($urandom_range(0, 11));
        y = (ma.pol == 8'hF0) ? x : 8'($urandom_range(0, 11));
        eb = (m_hitway(mb, y) >= 0);
        step(1'b1, 1'b0, 8'h00, 1'b1, x, y);
        if (ma.pol == 8'hF0) chk("iso_hit", hit_a, eb);
      end
    end
    idle();
    chk("iso_tags", tags_a[63:32], mb.tags[63:32]);
    chk("iso_valid", valid_a[7:4], mb.valid[7:4]);
    chk("iso_meta", meta_a[7:4], mb.meta[7:4]);

    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
    os(8'hFF);
    for (int i = 0; i < 8; i++) req(8'(8'h40 + i));
    req(8'h40);
    req(8'h44);
    idle();
    chk("plru_meta", meta_p, 8'h5C);
    chk("plru_root", meta_p[1], 1'b0);
    os(8'h03);
    req(8'h41);
    idle();
    chk("plru_m03_w1", meta_p, 8'h4C);
    req(8'h40);
    idle();
    chk("plru_m03_w0", meta_p, 8'h5C);

    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 99);
      hm = (r % 7 == 6) ? 8'($urandom)
                        : hms[r % 6];
      x = 8'($urandom_range(0, 15));
      y = 8'($urandom_range(0, 15));
      if (r == 99)
        step(1'b0, 1'b0, 8'h00, 1'b1, x, y);
      else
        step(1'b1, (r < 12), hm, ($urandom_range(0, 3) != 0), x, y);
    end
    idle();
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
